// File: rtl/multiply_seq.sv
// Sequential shift-add multiplier: one operand pair per start/done transaction,
// unsigned or two's-complement signed, WIDTH cycles of accumulation per product.
module multiply_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Magnitude of an operand; the most negative value maps onto itself, which is
  // still correct when read back as unsigned (2**(WIDTH-1)).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    logic [WIDTH-1:0] m;
    if (sgn && v[WIDTH-1]) begin
      m = ~v + WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic                sign_q, sign_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   out_q, out_d;
  logic [PROD_W-1:0]   result_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; CALC runs exactly WIDTH cycles regardless of data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture and shift-add datapath.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = magnitude(in0, is_signed);
          mplier_d = magnitude(in1, is_signed);
          sign_d   = is_signed & (in0[WIDTH-1] ^ in1[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          mcand_d  = mcand_q;
          mplier_d = mplier_q;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + (PROD_W'(mcand_q) << cnt_q);
        end else begin
          acc_d = acc_q;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Sign restoration; negating zero yields zero, so no negative-zero case.
  always_comb begin
    if (sign_q) begin
      result_s = ~acc_q + PROD_W'(1);
    end else begin
      result_s = acc_q;
    end
  end

  // Output logic: busy follows the next state, done and out update on leaving DONE.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    out_d  = out_q;
    if (state_q == ST_DONE) begin
      done_d = 1'b1;
      out_d  = result_s;
    end else begin
      done_d = 1'b0;
      out_d  = out_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_multiply_seq.sv
// Directed and random checks of multiply_seq at WIDTH=8: products, latency,
// pulse width, ignored restarts, mid-calculation reset and back-to-back operation.
module tb_multiply_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int total;
  int bad;

  multiply_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .in0       (in0),
    .in1       (in1),
    .busy      (busy),
    .done      (done),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction from IDLE; optional restart poke at CALC cycle 3.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input bit poke, input string name);
    int lat;
    int busy_cnt;
    int done_cnt;
    logic [15:0] res;
    lat = -1; busy_cnt = 0; done_cnt = 0; res = 16'h0;
    @(negedge clk);
    in0 = a; in1 = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in0 = ~a; in1 = ~b; is_signed = ~s;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (poke && k == 3) begin
        start = 1'b1; in0 = 8'h11; in1 = 8'h22; is_signed = 1'b0;
      end else if (poke && k == 4) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          res = out;
        end
      end
    end
    check({name, " out"}, 32'(res), 32'(exp));
    check({name, " latency"}, 32'(lat), 32'd9);
    check({name, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, " busy_cnt"}, 32'(busy_cnt), 32'd9);
    check({name, " out_hold"}, 32'(out), 32'(exp));
  endtask

  vec_t vecs[14];

  initial begin
    int ndone;
    int last_done;
    int cyc;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [15:0] rexp;
    logic signed [15:0] sprod;

    total = 0; bad = 0;
    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[4]  = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    vecs[5]  = '{8'h00, 8'hA5, 1'b1, 16'h0000};
    vecs[6]  = '{8'hA5, 8'h00, 1'b1, 16'h0000};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[10] = '{8'h03, 8'hFD, 1'b1, 16'hFFF7};
    vecs[11] = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    vecs[12] = '{8'h0C, 8'h0D, 1'b1, 16'd156};
    vecs[13] = '{8'h80, 8'h02, 1'b0, 16'h0100};

    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; in0 = 8'h0; in1 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", 32'(out), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Restart mid-CALC must be ignored.
    run_txn(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1, "restart_ignored");

    // Asynchronous reset at CALC cycle 4 aborts the transaction.
    @(negedge clk);
    in0 = 8'h55; in1 = 8'h66; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort done", 32'(done), 32'd0);
    begin
      int dseen;
      dseen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) dseen++;
      end
      reset_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done) dseen++;
      end
      check("abort no_done", 32'(dseen), 32'd0);
      check("abort idle", 32'(busy), 32'd0);
    end
    run_txn(8'd12, 8'd13, 1'b0, 16'd156, 1'b0, "after_abort");

    // Random sweep with start held high: one result every 10 cycles.
    ndone = 0; last_done = -1;
    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
    @(negedge clk);
    in0 = ra; in1 = rb; is_signed = rs; start = 1'b1;
    for (cyc = 0; cyc < 12000 && ndone < 1000; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (rs) begin
          sprod = $signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb});
          rexp  = 16'(sprod);
        end else begin
          rexp = {8'h00, ra} * {8'h00, rb};
        end
        check($sformatf("rand%0d out a=%0h b=%0h s=%0d", ndone, ra, rb, rs), 32'(out), 32'(rexp));
        if (last_done >= 0) begin
          check($sformatf("rand%0d spacing", ndone), 32'(cyc - last_done), 32'd10);
        end
        last_done = cyc;
        ndone++;
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        in0 = ra; in1 = rb; is_signed = rs;
      end
    end
    check("rand count", 32'(ndone), 32'd1000);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("final idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
